multi_alarm_clock: RTL and testbench
====================================

// Module: multi_alarm_clock
// PURPOSE
// Next-generation day/time/alarm core for the lab clock. Keeps sec/min/hr/day-of-week and holds NUM_ALARMS alarms.
// Each alarm has its own weekday mask, latched ringing, snooze and auto-timeout. Drives BCD digits to the
// existing 7-seg decoders, plus Buzz and the index of the ringing alarm.
// PARAMETERS
// NUM_ALARMS    4         alarm slots; AW = max(1,$clog2(NUM_ALARMS))
// DAYS          7         days per week; DW = $clog2(DAYS)
// DEFAULT_MASK  7'b0011111  per-alarm reset day mask, bit d = ring on day d (DAYS bits)
// SNOOZE_MIN    9         minutes until a snoozed alarm re-rings (1..59)
// TIMEOUT_MIN   5         minutes a ringing alarm buzzes before auto-clear (1..59)
// PORTS
// Clk       in   1     system clock
// Reset     in   1     synchronous, active-high reset
// Pulse     in   1     one-cycle seconds tick enable
// Timeset   in   1     time-set mode
// Alarmset  in   1     alarm-set mode for slot Alarmsel
// Minadv    in   1     advance minute (set modes)
// Hrsadv    in   1     advance hour (set modes)
// Dayadv    in   1     advance day (Timeset only)
// Alarmsel  in   AW    slot edited/displayed in Alarmset
// Maskld    in   1     in Alarmset: load Daymask into selected slot mask
// Daymask   in   DAYS  mask value for Maskld
// Alarmon   in   NUM_ALARMS  per-slot enable
// Snooze    in   1     one-cycle snooze request
// H1,H0,M1,M0,S1,S0  out  4 each  BCD display digits
// D0        out  DW    current day (never alarm-dependent)
// Buzz      out  1     any slot ringing (registered)
// Buzz_id   out  AW    lowest-index ringing slot; 0 when Buzz=0
// BEHAVIOUR
// - Reset: time 00:00:00, day 0; all alarms 00:00, mask=DEFAULT_MASK; ringing/snooze/timeout cleared; Buzz=0; Buzz_id=0.
// - All state changes occur only on Clk edges where Pulse=1, except Reset, Maskld, Snooze, and Alarmon clears.
//   Those act on any edge.
// - Run (Timeset=0): sec 59->0 carries to min; min 59->0 carries to hr; hr 23->0 carries to day; day DAYS-1->0.
// - Timeset=1 (priority over Alarmset): sec forced 0. Each Pulse: Minadv min+1 (wrap, no carry),
//   Hrsadv hr+1 (wrap, no carry), Dayadv day+1 (wrap). Multiple adv inputs apply together.
//   No alarm matches while Timeset=1.
// - Alarmset=1, Timeset=0: time keeps running. Minadv/Hrsadv edit slot Alarmsel (wrap, no carry); Dayadv ignored.
//   Editing a slot clears its snooze and ringing.
//   Digits show the slot's hh:mm:00; D0 still shows the current day.
// - Match: on a Pulse edge producing new time hh:mm:00, slot i fires if Alarmon[i] and either
//   (a) alarm hh:mm matches and mask[day]=1, or (b) snooze active and snooze hh:mm matches (mask ignored).
//   Fire sets ring[i], clears snooze[i], loads timeout[i]=TIMEOUT_MIN.
// - Buzz/Buzz_id are registered from ring[]: they rise the cycle after the firing edge.
// - Ringing slot: timeout decrements at each minute rollover; at 0, ring clears.
//   Alarmon[i]=0 clears ring[i] and snooze[i] on the next edge.
// - Snooze while Buzz=1: every ringing slot clears ring and sets snooze hh:mm = current hh:mm + SNOOZE_MIN (mod 24h).
//   Snooze while Buzz=0 is ignored.
// - If Snooze and a fire for the same slot happen on the same edge, the fire wins: the slot stays ringing and is not snoozed.
// - Reset mid-ring or mid-set returns all state to reset values on that edge.
// - Time is held in binary; BCD digits are produced combinationally via /10 and %10. Outputs are 4-bit BCD, range 0..9.
// STRUCTURE
// - Package alarm_clk_pkg: typedef hm_t {logic[4:0] hr; logic[5:0] min;}, constants MAX_SEC=59, MAX_MIN=59, MAX_HR=23,
//   and function hm_add(hm_t, int) (mod-24h add).
// - Sub-module alarm_slot: one per alarm, generated NUM_ALARMS times. Holds alarm hm, mask, snooze hm, ring, timeout.
//   Inputs: now, day, minute_tick, edit strobes. Output: ring.
// - Top level holds: the time/day counters, mode muxing, priority encoder for Buzz_id, and BCD split.
// TESTING
// 1. Reset; Timeset=1, Minadv for 50 Pulses, Hrsadv for 7, Dayadv for 4 -> D0=4, 07:50:00, Buzz=0.
// 2. Alarmset, Alarmsel=0, Hrsadv 8, Minadv 1; Alarmon=4'b0001; run -> Buzz=1, Buzz_id=0 one cycle after 08:01:00.
//    Buzz held until 08:06:00, then 0.
// 3. Continue 24h steps -> Buzz fires on days 4 and 0; does not fire on days 5 or 6 (DEFAULT_MASK).
// 4. Snooze at 08:01:30 -> Buzz=0 next cycle; Buzz=1 again after 08:10:00. Alarmon[0]=0 during snooze -> no re-ring.
// 5. Slots 1 and 2 both at 09:00 -> Buzz_id=1; drop Alarmon[1] -> Buzz_id=2; Maskld mask=0 on slot 3 -> slot 3 never rings.
// 6. Day 6, 23:59:59, Pulse -> day 0, 00:00:00. Reset asserted while Buzz=1 -> all outputs at reset values next edge.

Source files
------------

// File: rtl/alarm_clk_pkg.sv
// Shared types and helpers for the multi-alarm clock: hour/minute pair and mod-24h arithmetic.
// Pure declarations; no latency, no flow control.
package alarm_clk_pkg;

  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] min;
  } hm_t;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [4:0] MAX_HR  = 5'd23;

  // Adds m minutes to a, wrapping through midnight.
  function automatic hm_t hm_add(hm_t a, int m);
    int  t;
    hm_t r;
    t     = (int'(a.hr) * 60 + int'(a.min) + m) % 1440;
    r.hr  = 5'(t / 60);
    r.min = 6'(t % 60);
    return r;
  endfunction

endpackage

// File: rtl/multi_alarm_clock_if.sv
// Control inputs and display outputs of the multi-alarm clock core.
// Plain wires; master drives controls, slave (the core) drives the display.
interface multi_alarm_clock_if #(
  parameter int NUM_ALARMS = 4,
  parameter int DAYS       = 7
);
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int DW = $clog2(DAYS);

  logic                  Pulse;
  logic                  Timeset;
  logic                  Alarmset;
  logic                  Minadv;
  logic                  Hrsadv;
  logic                  Dayadv;
  logic [AW-1:0]         Alarmsel;
  logic                  Maskld;
  logic [DAYS-1:0]       Daymask;
  logic [NUM_ALARMS-1:0] Alarmon;
  logic                  Snooze;
  logic [3:0]            H1, H0, M1, M0, S1, S0;
  logic [DW-1:0]         D0;
  logic                  Buzz;
  logic [AW-1:0]         Buzz_id;

  modport master (
    output Pulse, Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmsel, Maskld, Daymask, Alarmon, Snooze,
    input  H1, H0, M1, M0, S1, S0, D0, Buzz, Buzz_id
  );

  modport slave (
    input  Pulse, Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmsel, Maskld, Daymask, Alarmon, Snooze,
    output H1, H0, M1, M0, S1, S0, D0, Buzz, Buzz_id
  );

endinterface

// File: rtl/alarm_slot.sv
// One alarm slot: alarm time, weekday mask, snooze time, latched ring and auto-timeout.
// Ring updates on the edge a match is seen; no backpressure, strobes act when presented.
module alarm_slot
  import alarm_clk_pkg::*;
#(
  parameter int              DAYS         = 7,
  parameter logic [DAYS-1:0] DEFAULT_MASK = 7'b0011111,
  parameter int              SNOOZE_MIN   = 9,
  parameter int              TIMEOUT_MIN  = 5
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  hm_t                     now_hm,
  input  hm_t                     next_hm,
  input  logic [$clog2(DAYS)-1:0] next_day,
  input  logic                    minute_tick,
  input  logic                    enable,
  input  logic                    edit_min,
  input  logic                    edit_hr,
  input  logic                    mask_ld,
  input  logic [DAYS-1:0]         daymask,
  input  logic                    snooze_req,
  output logic                    ring,
  output hm_t                     alarm_hm
);

  logic [DAYS-1:0] mask;
  hm_t             snz_hm;
  logic            snz_act;
  logic [5:0]      timeout;
  logic            fire;

  assign fire = minute_tick & enable &
                (((alarm_hm == next_hm) & mask[next_day]) | (snz_act & (snz_hm == next_hm)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      alarm_hm <= '0;
      mask     <= DEFAULT_MASK;
      snz_hm   <= '0;
      snz_act  <= 1'b0;
      ring     <= 1'b0;
      timeout  <= '0;
    end else begin
      if (mask_ld)
        mask <= daymask;
      if (edit_min)
        alarm_hm.min <= (alarm_hm.min == MAX_MIN) ? '0 : alarm_hm.min + 6'd1;
      if (edit_hr)
        alarm_hm.hr <= (alarm_hm.hr == MAX_HR) ? '0 : alarm_hm.hr + 5'd1;

      // A fire on the same edge as a snooze request wins over the snooze.
      if (!enable || edit_min || edit_hr) begin
        ring    <= 1'b0;
        snz_act <= 1'b0;
      end else if (fire) begin
        ring    <= 1'b1;
        snz_act <= 1'b0;
        timeout <= 6'(TIMEOUT_MIN);
      end else if (snooze_req && ring) begin
        ring    <= 1'b0;
        snz_act <= 1'b1;
        snz_hm  <= hm_add(now_hm, SNOOZE_MIN);
      end else if (ring && minute_tick) begin
        timeout <= timeout - 6'd1;
        if (timeout <= 6'd1)
          ring <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// Day/time keeper with NUM_ALARMS alarm slots, BCD display and registered buzz outputs.
// Buzz/Buzz_id lag ring by one cycle; no backpressure, time advances only on Pulse.
module multi_alarm_clock
  import alarm_clk_pkg::*;
#(
  parameter int              NUM_ALARMS   = 4,
  parameter int              DAYS         = 7,
  parameter logic [DAYS-1:0] DEFAULT_MASK = 7'b0011111,
  parameter int              SNOOZE_MIN   = 9,
  parameter int              TIMEOUT_MIN  = 5
) (
  input logic               Clk,
  input logic               Reset,
  multi_alarm_clock_if.slave bus
);

  localparam int              AW       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int              DW       = $clog2(DAYS);
  localparam logic [DW-1:0]   LAST_DAY = DW'(DAYS - 1);

  logic [5:0]            sec, nsec, min, nmin;
  logic [4:0]            hr, nhr;
  logic [DW-1:0]         day, nday;
  logic                  alm_mode, minute_tick, snooze_req;
  hm_t                   now_hm, next_hm;
  logic [NUM_ALARMS-1:0] ring;
  hm_t                   alarm_hm [NUM_ALARMS];
  logic                  buzz_q;
  logic [AW-1:0]         buzz_id_q, lowest;
  logic [4:0]            disp_hr;
  logic [5:0]            disp_min, disp_sec;

  assign alm_mode    = bus.Alarmset & ~bus.Timeset;
  assign minute_tick = bus.Pulse & ~bus.Timeset & (sec == MAX_SEC);
  assign snooze_req  = bus.Snooze & buzz_q;
  assign now_hm.hr   = hr;
  assign now_hm.min  = min;
  assign next_hm.hr  = nhr;
  assign next_hm.min = nmin;

  always_comb begin
    nsec = sec;
    nmin = min;
    nhr  = hr;
    nday = day;
    if (bus.Pulse) begin
      if (bus.Timeset) begin
        nsec = '0;
        if (bus.Minadv) nmin = (min == MAX_MIN) ? '0 : min + 6'd1;
        if (bus.Hrsadv) nhr  = (hr == MAX_HR) ? '0 : hr + 5'd1;
        if (bus.Dayadv) nday = (day == LAST_DAY) ? '0 : day + DW'(1);
      end else if (sec != MAX_SEC) begin
        nsec = sec + 6'd1;
      end else begin
        nsec = '0;
        if (min != MAX_MIN) begin
          nmin = min + 6'd1;
        end else begin
          nmin = '0;
          if (hr != MAX_HR) begin
            nhr = hr + 5'd1;
          end else begin
            nhr  = '0;
            nday = (day == LAST_DAY) ? '0 : day + DW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sec <= '0;
      min <= '0;
      hr  <= '0;
      day <= '0;
    end else begin
      sec <= nsec;
      min <= nmin;
      hr  <= nhr;
      day <= nday;
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
    logic sel;
    assign sel = (bus.Alarmsel == AW'(i));

    alarm_slot #(
      .DAYS         (DAYS),
      .DEFAULT_MASK (DEFAULT_MASK),
      .SNOOZE_MIN   (SNOOZE_MIN),
      .TIMEOUT_MIN  (TIMEOUT_MIN)
    ) u_slot (
      .Clk         (Clk),
      .Reset       (Reset),
      .now_hm      (now_hm),
      .next_hm     (next_hm),
      .next_day    (nday),
      .minute_tick (minute_tick),
      .enable      (bus.Alarmon[i]),
      .edit_min    (bus.Pulse & alm_mode & sel & bus.Minadv),
      .edit_hr     (bus.Pulse & alm_mode & sel & bus.Hrsadv),
      .mask_ld     (alm_mode & sel & bus.Maskld),
      .daymask     (bus.Daymask),
      .snooze_req  (snooze_req),
      .ring        (ring[i]),
      .alarm_hm    (alarm_hm[i])
    );
  end

  // Descending scan so the lowest ringing index is the one left standing.
  always_comb begin
    lowest = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (ring[i]) lowest = AW'(i);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      buzz_q    <= 1'b0;
      buzz_id_q <= '0;
    end else begin
      buzz_q    <= |ring;
      buzz_id_q <= lowest;
    end
  end

  always_comb begin
    disp_hr  = hr;
    disp_min = min;
    disp_sec = sec;
    if (alm_mode) begin
      disp_hr  = alarm_hm[bus.Alarmsel].hr;
      disp_min = alarm_hm[bus.Alarmsel].min;
      disp_sec = '0;
    end
  end

  assign bus.H1      = 4'(disp_hr / 5'd10);
  assign bus.H0      = 4'(disp_hr % 5'd10);
  assign bus.M1      = 4'(disp_min / 6'd10);
  assign bus.M0      = 4'(disp_min % 6'd10);
  assign bus.S1      = 4'(disp_sec / 6'd10);
  assign bus.S0      = 4'(disp_sec % 6'd10);
  assign bus.D0      = day;
  assign bus.Buzz    = buzz_q;
  assign bus.Buzz_id = buzz_id_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock: set modes, alarm firing, weekday mask, snooze, timeout, priority, wrap, reset.
module tb_multi_alarm_clock;

  logic Clk = 1'b0;
  logic Reset;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 Clk = ~Clk;

  multi_alarm_clock_if #(.NUM_ALARMS(4), .DAYS(7)) bus ();

  multi_alarm_clock #(
    .NUM_ALARMS   (4),
    .DAYS         (7),
    .DEFAULT_MASK (7'b0011111),
    .SNOOZE_MIN   (9),
    .TIMEOUT_MIN  (5)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bcd6(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk_time(input string tag, input int h, input int m, input int s, input int d);
    chk({tag, "_hms"}, 32'({bus.H1, bus.H0, bus.M1, bus.M0, bus.S1, bus.S0}), 32'(bcd6(h, m, s)));
    chk({tag, "_day"}, 32'(bus.D0), 32'(d));
  endtask

  task automatic chk_buzz(input string tag, input int b, input int id);
    chk({tag, "_buzz"}, 32'(bus.Buzz), 32'(b));
    chk({tag, "_id"}, 32'(bus.Buzz_id), 32'(id));
  endtask

  // Called at a negedge; leaves Pulse high for n rising edges and returns at a negedge.
  task automatic tick_n(input int n);
    bus.Pulse = 1'b1;
    repeat (n) @(negedge Clk);
    bus.Pulse = 1'b0;
  endtask

  task automatic idle();
    @(negedge Clk);
  endtask

  // Moves to the next day, rewinds minutes to hh:00 and runs up to hh:01:00.
  task automatic next_day_to_0801(input int madv);
    bus.Timeset = 1'b1;
    bus.Dayadv  = 1'b1;
    tick_n(1);
    bus.Dayadv  = 1'b0;
    bus.Minadv  = 1'b1;
    tick_n(madv);
    bus.Minadv  = 1'b0;
    bus.Timeset = 1'b0;
    tick_n(60);
    idle();
  endtask

  initial begin
    Reset        = 1'b1;
    bus.Pulse    = 1'b0;
    bus.Timeset  = 1'b0;
    bus.Alarmset = 1'b0;
    bus.Minadv   = 1'b0;
    bus.Hrsadv   = 1'b0;
    bus.Dayadv   = 1'b0;
    bus.Alarmsel = '0;
    bus.Maskld   = 1'b0;
    bus.Daymask  = '0;
    bus.Alarmon  = '0;
    bus.Snooze   = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    chk_time("reset", 0, 0, 0, 0);
    chk_buzz("reset", 0, 0);

    // Time set: minutes, hours, days with no carries
    bus.Timeset = 1'b1;
    bus.Minadv  = 1'b1;
    tick_n(50);
    bus.Minadv  = 1'b0;
    bus.Hrsadv  = 1'b1;
    tick_n(7);
    bus.Hrsadv  = 1'b0;
    bus.Dayadv  = 1'b1;
    tick_n(4);
    bus.Dayadv  = 1'b0;
    chk_time("tset", 7, 50, 0, 4);
    chk_buzz("tset", 0, 0);

    // Slot 0 to 08:01 while time keeps running
    bus.Timeset  = 1'b0;
    bus.Alarmset = 1'b1;
    bus.Alarmsel = 2'd0;
    bus.Hrsadv   = 1'b1;
    tick_n(8);
    bus.Hrsadv   = 1'b0;
    bus.Minadv   = 1'b1;
    tick_n(1);
    bus.Minadv   = 1'b0;
    #1;
    chk_time("aset_disp", 8, 1, 0, 4);
    bus.Alarmset = 1'b0;
    #1;
    chk_time("run_disp", 7, 50, 9, 4);

    bus.Alarmon = 4'b0001;
    tick_n(650);
    chk_time("pre_fire", 8, 0, 59, 4);
    chk_buzz("pre_fire", 0, 0);
    tick_n(1);
    chk_buzz("fire_edge", 0, 0);
    idle();
    chk_buzz("fire", 1, 0);
    tick_n(299);
    chk_buzz("hold", 1, 0);
    tick_n(1);
    idle();
    chk_time("timeout", 8, 6, 0, 4);
    chk_buzz("timeout", 0, 0);

    // Weekday mask: days 5 and 6 masked off, day 0 enabled
    next_day_to_0801(54);
    chk_time("day5", 8, 1, 0, 5);
    chk_buzz("day5", 0, 0);
    next_day_to_0801(59);
    chk_time("day6", 8, 1, 0, 6);
    chk_buzz("day6", 0, 0);
    next_day_to_0801(59);
    chk_time("day0", 8, 1, 0, 0);
    chk_buzz("day0", 1, 0);

    // Snooze at 08:01:30, re-ring at 08:10:00
    tick_n(30);
    bus.Snooze = 1'b1;
    idle();
    bus.Snooze = 1'b0;
    idle();
    chk_buzz("snoozed", 0, 0);
    tick_n(509);
    idle();
    chk_time("pre_snz", 8, 9, 59, 0);
    chk_buzz("pre_snz", 0, 0);
    tick_n(1);
    idle();
    chk_time("snz_ring", 8, 10, 0, 0);
    chk_buzz("snz_ring", 1, 0);

    // Snooze again, then disable slot 0 briefly: the pending snooze must be dropped
    bus.Snooze  = 1'b1;
    idle();
    bus.Snooze  = 1'b0;
    bus.Alarmon = 4'b0000;
    idle();
    bus.Alarmon = 4'b0001;
    chk_buzz("snz2", 0, 0);
    tick_n(540);
    idle();
    chk_time("no_rering", 8, 19, 0, 0);
    chk_buzz("no_rering", 0, 0);

    // Slots 1..3 at 09:00; slot 3 mask cleared
    bus.Alarmset = 1'b1;
    bus.Hrsadv   = 1'b1;
    bus.Alarmsel = 2'd1;
    tick_n(9);
    bus.Alarmsel = 2'd2;
    tick_n(9);
    bus.Alarmsel = 2'd3;
    tick_n(9);
    bus.Hrsadv   = 1'b0;
    bus.Daymask  = 7'b0000000;
    bus.Maskld   = 1'b1;
    idle();
    bus.Maskld   = 1'b0;
    #1;
    chk_time("slot3_disp", 9, 0, 0, 0);
    bus.Alarmset = 1'b0;
    bus.Alarmon  = 4'b1110;
    tick_n(2432);
    chk_time("pre_nine", 8, 59, 59, 0);
    chk_buzz("pre_nine", 0, 0);
    tick_n(1);
    idle();
    chk_buzz("two_ring", 1, 1);
    bus.Alarmon = 4'b1100;
    idle();
    idle();
    chk_buzz("drop1", 1, 2);
    bus.Alarmon = 4'b1000;
    idle();
    idle();
    chk_buzz("slot3_masked", 0, 0);

    // Simultaneous adv inputs, then end-of-week wrap
    bus.Timeset = 1'b1;
    bus.Dayadv  = 1'b1;
    bus.Hrsadv  = 1'b1;
    bus.Minadv  = 1'b1;
    tick_n(6);
    bus.Dayadv  = 1'b0;
    tick_n(8);
    bus.Hrsadv  = 1'b0;
    tick_n(45);
    bus.Minadv  = 1'b0;
    chk_time("set_multi", 23, 59, 0, 6);
    bus.Timeset = 1'b0;
    tick_n(59);
    chk_time("eow", 23, 59, 59, 6);
    tick_n(1);
    chk_time("wrap", 0, 0, 0, 0);

    // Reset while slot 1 rings
    bus.Timeset = 1'b1;
    bus.Hrsadv  = 1'b1;
    bus.Minadv  = 1'b1;
    tick_n(8);
    bus.Hrsadv  = 1'b0;
    tick_n(51);
    bus.Minadv  = 1'b0;
    bus.Timeset = 1'b0;
    bus.Alarmon = 4'b0010;
    tick_n(60);
    idle();
    chk_buzz("pre_reset", 1, 1);
    Reset = 1'b1;
    idle();
    chk_buzz("reset_ring", 0, 0);
    chk_time("reset_ring", 0, 0, 0, 0);
    Reset        = 1'b0;
    bus.Alarmset = 1'b1;
    bus.Alarmsel = 2'd1;
    #1;
    chk_time("reset_slot", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
